opll_bus_writer: RTL and testbench
==================================

Name: opll_bus_writer

Overview:
- Host-side bus master that drives the YM2413-compatible write bus (D[7:0], A0, CS_n, WR_n) of the OPLL core.
- Takes (register, value) write requests over a valid/ready interface and buffers them in a small FIFO.
- Replays each request as an address write then a data write, enforcing the chip's mandatory post-write wait times.
- Sits in front of the sound core, so firmware or a test sequencer can stream register writes without counting clocks.

Parameters:
- STROBE_LEN, 2: cycles CS_n/WR_n are held low per write (≥1).
- ADDR_WAIT, 12: idle cycles after address-write strobe before the data write (≥1).
- DATA_WAIT, 84: idle cycles after data-write strobe before the next address write (≥1).
- FIFO_DEPTH, 4: request buffer entries (power of two, ≥2).

Ports:
- clk  in  1  master clock; same clock as the OPLL core's XIN.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  write request present.
- o_ready  out  1  request accepted this cycle when i_valid&o_ready; equals FIFO not full.
- i_addr  in  8  OPLL register address.
- i_data  in  8  register value.
- o_D  out  8  bus data to OPLL.
- o_A0  out  1  0 = address phase, 1 = data phase.
- o_CS_n  out  1  chip select, active-low.
- o_WR_n  out  1  write strobe, active-low.
- o_busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- o_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - o_CS_n=1, o_WR_n=1, o_A0=0, o_D=0, o_busy=0, o_level=0, o_ready=1.
  - FIFO cleared; FSM goes to IDLE.
  - Asserting reset mid-strobe raises the strobes immediately, without waiting for a clock edge.
- FIFO:
  - Push on i_valid&o_ready.
  - Pop when the FSM takes an entry.
  - Simultaneous push and pop when full is not allowed, because o_ready=0 when full.
  - Simultaneous push and pop at any other level leaves o_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP_A, STROBE_A, WAIT_A, SETUP_D, STROBE_D, WAIT_D.
- IDLE:
  - If the FIFO is non-empty: pop, latch addr/data, go to SETUP_A.
  - A request pushed into an empty FIFO at edge N is popped at edge N+1.
- SETUP_A: 1 cycle; o_A0=0, o_D=addr, strobes high.
- STROBE_A: STROBE_LEN cycles; o_CS_n=o_WR_n=0; A0 and D held.
- WAIT_A: ADDR_WAIT cycles; strobes high; A0 and D held.
- SETUP_D: 1 cycle; o_A0=1, o_D=data, strobes high.
- STROBE_D: STROBE_LEN cycles; strobes low; A0 and D held.
- WAIT_D: DATA_WAIT cycles; strobes high.
  - On the last cycle, if the FIFO is non-empty: pop and go directly to SETUP_A (no IDLE cycle).
  - Otherwise go to IDLE.
- A0 and D change only on entry to a SETUP state. Otherwise they hold their last value, including in IDLE.
- Strobes are driven from registers, so they are glitch-free. o_CS_n and o_WR_n are always equal.
- Write period:
  - Back-to-back: 2+2·STROBE_LEN+ADDR_WAIT+DATA_WAIT cycles (102 at defaults).
  - From IDLE: one additional cycle.
- One shared down-counter covers the strobe and wait states.
  - Width is clog2(max(STROBE_LEN,ADDR_WAIT,DATA_WAIT)+1).
  - Loaded with N-1 on state entry; the state exits when the counter reads 0.
- o_busy deasserts in the first IDLE cycle after the final WAIT_D.
- Requests arriving during any state are only buffered; an in-flight write is never aborted or reordered.

Test Plan:
- Reset values: hold rst_n=0, toggle clk → CS_n=WR_n=1, A0=0, D=0, o_ready=1, o_level=0, o_busy=0.
- Single write: push (0x10, 0x5A) into an empty FIFO at edge N.
  - SETUP_A entered at edge N+1 with D=0x10, A0=0.
  - CS_n/WR_n low for exactly 2 cycles starting at edge N+2.
  - 12 idle cycles, then D=0x5A, A0=1; strobe low 2 cycles; 84 wait cycles.
  - Then IDLE and o_busy=0.
  - With the OPLL core attached, register 0x10 reads back as 0x5A.
- Back-to-back: push 3 requests in 3 consecutive cycles.
  - All accepted; o_level peaks at 2.
  - Consecutive address-strobe falling edges are exactly 102 cycles apart.
  - Address/data bytes appear in push order.
- Full FIFO: push 6 requests continuously with FIFO_DEPTH=4.
  - o_ready drops once 4 entries are buffered after the first pop, i.e. the 6th request stalls.
  - It is accepted the cycle after the next pop.
  - No request is lost or duplicated.
- Simultaneous push and pop: push a request on the exact cycle WAIT_D ends with o_level=1 → o_level stays 1; SETUP_A follows with no IDLE cycle.
- Reset mid-strobe: assert rst_n=0 during STROBE_D → CS_n/WR_n go high asynchronously, FIFO empties; after release the FSM is IDLE and a new write runs normally.

Source files
------------

// File: rtl/opll_bus_writer.sv
// OPLL host write-bus master: buffers (register, value) requests and replays each
// as an address write then a data write, honouring the chip's post-write recovery gaps.
module opll_bus_writer #(
   parameter int STROBE_LEN = 2,
   parameter int ADDR_WAIT  = 12,
   parameter int DATA_WAIT  = 84,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [7:0]                  i_addr,
   input  logic [7:0]                  i_data,
   output logic [7:0]                  o_D,
   output logic                        o_A0,
   output logic                        o_CS_n,
   output logic                        o_WR_n,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_level
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int MAX_SA = (STROBE_LEN > ADDR_WAIT) ? STROBE_LEN : ADDR_WAIT;
   localparam int MAX_N  = (MAX_SA > DATA_WAIT) ? MAX_SA : DATA_WAIT;
   localparam int CNT_W  = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
   localparam logic [CNT_W-1:0] ADDR_LOAD   = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] DATA_LOAD   = CNT_W'(DATA_WAIT - 1);
   localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, SETUP_A, STROBE_A, WAIT_A, SETUP_D, STROBE_D, WAIT_D
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [7:0]       d_reg, d_next;
   logic             a0_reg, a0_next;
   logic             strobe_n_reg, strobe_n_next;
   logic [7:0]       data_hold_reg, data_hold_next;

   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic [15:0]      head;
   logic             push, pop;

   assign o_ready = (level_reg != FULL_LEVEL);
   assign push    = i_valid & o_ready;
   assign head    = fifo_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= {i_addr, i_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop)
            level_reg <= level_reg + 1'b1;
         else if (pop && !push)
            level_reg <= level_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         d_reg         <= '0;
         a0_reg        <= 1'b0;
         strobe_n_reg  <= 1'b1;
         data_hold_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         d_reg         <= d_next;
         a0_reg        <= a0_next;
         strobe_n_reg  <= strobe_n_next;
         data_hold_reg <= data_hold_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      d_next         = d_reg;
      a0_next        = a0_reg;
      data_hold_next = data_hold_reg;
      pop            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (level_reg != '0) begin
               pop        = 1'b1;
               state_next = SETUP_A;
            end
         end
         SETUP_A: begin
            state_next = STROBE_A;
            cnt_next   = STROBE_LOAD;
         end
         STROBE_A: begin
            if (cnt_reg == '0) begin
               state_next = WAIT_A;
               cnt_next   = ADDR_LOAD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         WAIT_A: begin
            if (cnt_reg == '0)
               state_next = SETUP_D;
            else
               cnt_next = cnt_reg - 1'b1;
         end
         SETUP_D: begin
            state_next = STROBE_D;
            cnt_next   = STROBE_LOAD;
            d_next     = data_hold_reg;
            a0_next    = 1'b1;
         end
         STROBE_D: begin
            if (cnt_reg == '0) begin
               state_next = WAIT_D;
               cnt_next   = DATA_LOAD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         WAIT_D: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else if (level_reg != '0) begin
               // chain straight into the next write without an IDLE bubble
               pop        = 1'b1;
               state_next = SETUP_A;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (pop) begin
         d_next         = head[15:8];
         a0_next        = 1'b0;
         data_hold_next = head[7:0];
      end
      strobe_n_next = !((state_next == STROBE_A) || (state_next == STROBE_D));
   end

   assign o_D     = d_reg;
   assign o_A0    = a0_reg;
   assign o_CS_n  = strobe_n_reg;
   assign o_WR_n  = strobe_n_reg;
   assign o_level = level_reg;
   assign o_busy  = (state_reg != IDLE) || (level_reg != '0);

endmodule

// File: tb/tb_opll_bus_writer.sv
// Randomized bench for opll_bus_writer: every accepted request is scheduled by a
// transaction-level timing model and the observed bus strobes are compared to it.
`timescale 1ns/1ps
module tb_opll_bus_writer;
   localparam int SL     = 2;
   localparam int AW     = 12;
   localparam int DW     = 84;
   localparam int DEPTH  = 4;
   localparam int PERIOD = 2 + 2 * SL + AW + DW;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic       o_ready;
   logic [7:0] i_addr = '0;
   logic [7:0] i_data = '0;
   logic [7:0] o_D;
   logic       o_A0, o_CS_n, o_WR_n, o_busy;
   logic [2:0] o_level;

   opll_bus_writer #(
      .STROBE_LEN(SL), .ADDR_WAIT(AW), .DATA_WAIT(DW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_addr(i_addr), .i_data(i_data), .o_D(o_D), .o_A0(o_A0),
      .o_CS_n(o_CS_n), .o_WR_n(o_WR_n), .o_busy(o_busy), .o_level(o_level)
   );

   always #5 clk = ~clk;

   // edge index: at a negedge, cyc is the number of the most recent rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         start;
      int         len;
      logic       a0;
      logic [7:0] d;
   } strobe_t;

   strobe_t    obs_q[$];
   strobe_t    cur;
   bit         in_low = 1'b0;
   int         acc_edge[$];
   int         pop_edge[$];
   logic [7:0] acc_addr[$];
   logic [7:0] acc_data[$];
   int         last_pop = -1000;
   int         errors = 0;
   int         checks = 0;
   int         lvl_bad = 0, rdy_bad = 0, busy_bad = 0, pair_bad = 0, hold_bad = 0;
   int         lvl_peak = 0;

   always @(negedge clk) begin
      int lvl_m;
      int lp;
      bit busy_m;
      if (!rst_n) begin
         in_low = 1'b0;
      end else begin
         lvl_m = 0;
         lp    = -1000;
         foreach (acc_edge[i]) if (acc_edge[i] <= cyc) lvl_m++;
         foreach (pop_edge[i]) if (pop_edge[i] <= cyc) begin lvl_m--; lp = pop_edge[i]; end
         busy_m = (lvl_m > 0) || (cyc < lp + PERIOD);
         if (o_level !== 3'(lvl_m)) lvl_bad++;
         if (o_ready !== (lvl_m != DEPTH)) rdy_bad++;
         if (o_busy !== busy_m) busy_bad++;
         if (o_CS_n !== o_WR_n) pair_bad++;
         if (int'(o_level) > lvl_peak) lvl_peak = int'(o_level);
         if (o_CS_n === 1'b0) begin
            if (!in_low) begin
               in_low    = 1'b1;
               cur.start = cyc;
               cur.len   = 1;
               cur.a0    = o_A0;
               cur.d     = o_D;
            end else begin
               cur.len++;
               if (o_A0 !== cur.a0 || o_D !== cur.d) hold_bad++;
            end
         end else if (in_low) begin
            obs_q.push_back(cur);
            in_low = 1'b0;
         end
      end
   end

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Holds the request until accepted; a pop happens one edge after acceptance or
   // one full write period after the previous pop, whichever is later.
   task automatic send(input logic [7:0] a, input logic [7:0] d, output int e);
      int guard;
      int p;
      guard   = 0;
      e       = -1;
      i_valid = 1'b1;
      i_addr  = a;
      i_data  = d;
      while (e < 0) begin
         @(negedge clk);
         if (o_ready === 1'b1) begin
            e = cyc + 1;
            p = (e + 1 > last_pop + PERIOD) ? e + 1 : last_pop + PERIOD;
            acc_edge.push_back(e);
            acc_addr.push_back(a);
            acc_data.push_back(d);
            pop_edge.push_back(p);
            last_pop = p;
         end
         to_drive();
         guard++;
         if (e < 0 && guard > 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout addr=%02h waited=%0d cycles required acceptance", a, guard);
            break;
         end
      end
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (cyc < last_pop + PERIOD && guard < 2000);
   endtask

   task automatic wait_until_neg(input int target);
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (cyc < target && guard < 2000);
   endtask

   task automatic check_writes(input string name);
      int      n;
      int      idx;
      strobe_t e;
      n = acc_edge.size();
      checks++;
      if (obs_q.size() !== 2 * n) begin
         errors++;
         $display("FAIL %s strobe_count got=%0d exp=%0d", name, obs_q.size(), 2 * n);
      end
      for (int i = 0; i < n; i++) begin
         for (int ph = 0; ph < 2; ph++) begin
            e.start = pop_edge[i] + 1 + ph * (SL + AW + 1);
            e.len   = SL;
            e.a0    = (ph == 1);
            e.d     = (ph == 1) ? acc_data[i] : acc_addr[i];
            idx     = 2 * i + ph;
            if (idx < obs_q.size()) begin
               checks++;
               if (obs_q[idx].start !== e.start || obs_q[idx].len !== e.len ||
                   obs_q[idx].a0 !== e.a0 || obs_q[idx].d !== e.d) begin
                  errors++;
                  $display("FAIL %s strobe%0d got start=%0d len=%0d a0=%0b d=%02h exp start=%0d len=%0d a0=%0b d=%02h",
                           name, idx, obs_q[idx].start, obs_q[idx].len, obs_q[idx].a0, obs_q[idx].d,
                           e.start, e.len, e.a0, e.d);
               end
            end
         end
      end
      obs_q.delete();
      acc_edge.delete();
      acc_addr.delete();
      acc_data.delete();
      pop_edge.delete();
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (o_CS_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", o_CS_n); end
      checks++; if (o_WR_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n got=%b exp=1", o_WR_n); end
      checks++; if (o_A0 !== 1'b0) begin errors++; $display("FAIL reset_a0 got=%b exp=0", o_A0); end
      checks++; if (o_D !== 8'h00) begin errors++; $display("FAIL reset_d got=%02h exp=00", o_D); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", o_level); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      to_drive();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int e;
      to_drive();
      send(8'h10, 8'h5A, e);
      i_valid = 1'b0;
      wait_done();
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%b exp=0", o_busy); end
      checks++; if (o_D !== 8'h5A) begin errors++; $display("FAIL single_d_hold got=%02h exp=5a", o_D); end
      checks++; if (o_A0 !== 1'b1) begin errors++; $display("FAIL single_a0_hold got=%b exp=1", o_A0); end
      if (obs_q.size() > 0) begin
         checks++;
         if (obs_q[0].start !== e + 2) begin
            errors++;
            $display("FAIL single_first_strobe got=%0d exp=%0d", obs_q[0].start, e + 2);
         end
      end
      check_writes("single");
   endtask

   task automatic test_back_to_back();
      int e;
      lvl_peak = 0;
      to_drive();
      for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e);
      i_valid = 1'b0;
      wait_done();
      checks++; if (lvl_peak !== 2) begin errors++; $display("FAIL b2b_level_peak got=%0d exp=2", lvl_peak); end
      if (obs_q.size() >= 6) begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (obs_q[2 * i].start - obs_q[2 * i - 2].start !== PERIOD) begin
               errors++;
               $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i,
                        obs_q[2 * i].start - obs_q[2 * i - 2].start, PERIOD);
            end
         end
      end
      check_writes("back_to_back");
   endtask

   task automatic test_full();
      int e[6];
      to_drive();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            checks++;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", o_ready); end
         end
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e[i]);
      end
      i_valid = 1'b0;
      checks++; if (e[4] - e[0] !== 4) begin errors++; $display("FAIL full_fifth_accept got=%0d exp=4", e[4] - e[0]); end
      checks++;
      if (e[5] - e[0] !== PERIOD + 2) begin
         errors++;
         $display("FAIL full_sixth_accept got=%0d exp=%0d", e[5] - e[0], PERIOD + 2);
      end
      wait_done();
      check_writes("full");
   endtask

   task automatic test_simul();
      int ea, eb, ec;
      to_drive();
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ea);
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), eb);
      i_valid = 1'b0;
      wait_until_neg(ea + 101);
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL simul_level_before got=%0d exp=1", o_level); end
      to_drive();
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ec);
      i_valid = 1'b0;
      checks++; if (ec !== ea + PERIOD + 1) begin errors++; $display("FAIL simul_accept got=%0d exp=%0d", ec, ea + PERIOD + 1); end
      @(negedge clk);
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL simul_level_after got=%0d exp=1", o_level); end
      wait_done();
      check_writes("simul");
   endtask

   task automatic test_reset_mid();
      int e;
      int p;
      to_drive();
      for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e);
      i_valid = 1'b0;
      p = pop_edge[0];
      wait_until_neg(p + SL + AW + 2);
      checks++; if (o_CS_n !== 1'b0) begin errors++; $display("FAIL mid_in_strobe got=%b exp=0", o_CS_n); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (o_CS_n !== 1'b1 || o_WR_n !== 1'b1) begin errors++; $display("FAIL mid_async_strobe got=%b%b exp=11", o_CS_n, o_WR_n); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL mid_async_level got=%0d exp=0", o_level); end
      acc_edge.delete();
      acc_addr.delete();
      acc_data.delete();
      pop_edge.delete();
      last_pop = -1000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      obs_q.delete();
      to_drive();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_release_busy got=%b exp=0", o_busy); end
      to_drive();
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e);
      i_valid = 1'b0;
      wait_done();
      check_writes("after_reset");
   endtask

   task automatic test_monitors();
      checks++; if (lvl_bad !== 0) begin errors++; $display("FAIL mon_level bad_cycles=%0d exp=0", lvl_bad); end
      checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL mon_ready bad_cycles=%0d exp=0", rdy_bad); end
      checks++; if (busy_bad !== 0) begin errors++; $display("FAIL mon_busy bad_cycles=%0d exp=0", busy_bad); end
      checks++; if (pair_bad !== 0) begin errors++; $display("FAIL mon_cs_wr_equal bad_cycles=%0d exp=0", pair_bad); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL mon_strobe_hold bad_cycles=%0d exp=0", hold_bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_simul();
      test_reset_mid();
      test_monitors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
